// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core.
// Decides each cycle whether the PC/IF-ID hold, whether ID/EX takes a bubble,
// whether IF/ID is flushed, and whether the whole pipeline freezes while a
// fixed-latency data-memory access completes.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_RUN   | normal flow; a memory access seen here starts a freeze window
//   ST_WAIT  | pipeline frozen, r_cnt counts the remaining frozen cycles down
//   ST_RELEASE | one unfrozen cycle so the memory instruction advances;
//            | a memory access seen here is ignored
module hazard_stall_controller #(
    parameter int unsigned MEM_WAIT_CYCLES = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_src1,
    input  logic [4:0]       i_src2,
    input  logic             i_two_src,
    input  logic             i_forward_en,
    input  logic [4:0]       i_exe_dest,
    input  logic             i_exe_wb_en,
    input  logic             i_exe_mem_r_en,
    input  logic [4:0]       i_mem_dest,
    input  logic             i_mem_wb_en,
    input  logic             i_mem_r_en,
    input  logic             i_mem_w_en,
    input  logic             i_br_taken,
    output logic             o_freeze_pc,
    output logic             o_hazard_detected,
    output logic             o_flush_if,
    output logic             o_freeze_all,
    output logic             o_mem_busy,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // A zero wait count disables freezing altogether; a count of one skips WAIT.
    localparam logic       LP_FREEZE_EN = (MEM_WAIT_CYCLES != 0);
    localparam logic       LP_USE_WAIT  = (MEM_WAIT_CYCLES > 1);
    localparam logic [3:0] LP_CNT_INIT  = (MEM_WAIT_CYCLES > 0) ?
                                          4'(MEM_WAIT_CYCLES - 1) : 4'd0;
    localparam logic [CNT_W-1:0] LP_STALL_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_mem_access;
    logic w_fsm_freeze;
    logic w_src1_used;
    logic w_src2_used;
    logic w_exe_match;
    logic w_mem_match;
    logic w_dh;

    assign w_mem_access = i_mem_r_en | i_mem_w_en;

    // Source/destination matching; register 0 is never a real dependency.
    always_comb begin
        w_src1_used = (i_src1 != 5'd0);
        w_src2_used = i_two_src & (i_src2 != 5'd0);
        w_exe_match = i_exe_wb_en &
                      ((w_src1_used & (i_src1 == i_exe_dest)) |
                       (w_src2_used & (i_src2 == i_exe_dest)));
        w_mem_match = i_mem_wb_en &
                      ((w_src1_used & (i_src1 == i_mem_dest)) |
                       (w_src2_used & (i_src2 == i_mem_dest)));
    end

    // With forwarding only a load-use dependency stalls; without it any
    // in-flight producer in EXE or MEM does.
    always_comb begin
        if (i_forward_en) begin
            w_dh = i_exe_mem_r_en & w_exe_match;
        end else begin
            w_dh = w_exe_match | w_mem_match;
        end
    end

    // State register and freeze down-counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and freeze request for the memory-access sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_fsm_freeze = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_access && LP_FREEZE_EN) begin
                    w_fsm_freeze = 1'b1;
                    w_cnt_nxt    = LP_CNT_INIT;
                    w_state_nxt  = LP_USE_WAIT ? ST_WAIT : ST_RELEASE;
                end
            end
            ST_WAIT: begin
                w_fsm_freeze = 1'b1;
                w_cnt_nxt    = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Control output priority: reset, freeze, taken branch, data hazard.
    always_comb begin
        o_freeze_pc       = 1'b0;
        o_hazard_detected = 1'b0;
        o_flush_if        = 1'b0;
        o_freeze_all      = 1'b0;
        if (i_rst) begin
            o_freeze_pc = 1'b0;
        end else if (w_fsm_freeze) begin
            o_freeze_all = 1'b1;
            o_freeze_pc  = 1'b1;
        end else if (i_br_taken) begin
            o_flush_if        = 1'b1;
            o_hazard_detected = 1'b1;
        end else if (w_dh) begin
            o_freeze_pc       = 1'b1;
            o_hazard_detected = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
        end else if (o_freeze_pc && (r_stall_cycles != LP_STALL_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_mem_busy     = (r_state != ST_RUN);
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: one instance with the default
// 4-cycle memory freeze and a 32-bit counter, one with freezing disabled and
// a 4-bit counter for saturation.
module tb_hazard_stall_controller;

    logic       clk;
    logic       rst;
    logic [4:0] src1, src2, exe_dest, mem_dest;
    logic       two_src, forward_en, exe_wb_en, exe_mem_r_en;
    logic       mem_wb_en, mem_r_en, mem_w_en, br_taken;

    logic        a_fpc, a_hd, a_fif, a_fall, a_busy;
    logic [31:0] a_stall;
    logic        s_fpc, s_hd, s_fif, s_fall, s_busy;
    logic [3:0]  s_stall;

    int n_cmp = 0;
    int n_err = 0;

    hazard_stall_controller #(.MEM_WAIT_CYCLES(4), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_src1(src1), .i_src2(src2),
        .i_two_src(two_src), .i_forward_en(forward_en),
        .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en),
        .i_exe_mem_r_en(exe_mem_r_en), .i_mem_dest(mem_dest),
        .i_mem_wb_en(mem_wb_en), .i_mem_r_en(mem_r_en),
        .i_mem_w_en(mem_w_en), .i_br_taken(br_taken),
        .o_freeze_pc(a_fpc), .o_hazard_detected(a_hd), .o_flush_if(a_fif),
        .o_freeze_all(a_fall), .o_mem_busy(a_busy), .o_stall_cycles(a_stall)
    );

    hazard_stall_controller #(.MEM_WAIT_CYCLES(0), .CNT_W(4)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_src1(src1), .i_src2(src2),
        .i_two_src(two_src), .i_forward_en(forward_en),
        .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en),
        .i_exe_mem_r_en(exe_mem_r_en), .i_mem_dest(mem_dest),
        .i_mem_wb_en(mem_wb_en), .i_mem_r_en(mem_r_en),
        .i_mem_w_en(mem_w_en), .i_br_taken(br_taken),
        .o_freeze_pc(s_fpc), .o_hazard_detected(s_hd), .o_flush_if(s_fif),
        .o_freeze_all(s_fall), .o_mem_busy(s_busy), .o_stall_cycles(s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk_ctl(input string tag, input logic fpc, input logic hd,
                           input logic fif, input logic fall);
        chk1({tag, ".freeze_pc"}, a_fpc, fpc);
        chk1({tag, ".hazard"}, a_hd, hd);
        chk1({tag, ".flush_if"}, a_fif, fif);
        chk1({tag, ".freeze_all"}, a_fall, fall);
    endtask

    task automatic clear_inputs();
        src1 = 5'd0; src2 = 5'd0; exe_dest = 5'd0; mem_dest = 5'd0;
        two_src = 1'b0; forward_en = 1'b0; exe_wb_en = 1'b0;
        exe_mem_r_en = 1'b0; mem_wb_en = 1'b0; mem_r_en = 1'b0;
        mem_w_en = 1'b0; br_taken = 1'b0;
    endtask

    task automatic set_load_use();
        forward_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1;
        exe_dest = 5'd5; src1 = 5'd5;
    endtask

    logic exp_win [0:6];

    initial begin
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();

        // Outputs forced low while reset is held, even with hazards present.
        set_load_use();
        mem_r_en = 1'b1;
        br_taken = 1'b0;
        settle();
        chk_ctl("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("rst.mem_busy", a_busy, 1'b0);
        chkn("rst.stall", a_stall, 32'd0);
        cyc();
        rst = 1'b0;
        mem_r_en = 1'b0;

        // Load-use stall, same cycle.
        settle();
        chk_ctl("load_use", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chkn("load_use.stall", a_stall, 32'd1);

        // Register 0 never hazards.
        src1 = 5'd0; exe_dest = 5'd0;
        settle();
        chk_ctl("reg0", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // No forwarding: MEM producer matched on src2.
        clear_inputs();
        mem_wb_en = 1'b1; mem_dest = 5'd7; src2 = 5'd7; two_src = 1'b1;
        src1 = 5'd3;
        settle();
        chk_ctl("nofwd_src2", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        two_src = 1'b0;
        settle();
        chk_ctl("nofwd_one_src", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        two_src = 1'b1; forward_en = 1'b1;
        settle();
        chk_ctl("fwd_mem_ok", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Forwarding on but EXE is not a load: no stall.
        clear_inputs();
        set_load_use();
        exe_mem_r_en = 1'b0;
        settle();
        chk_ctl("fwd_alu", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Taken branch overrides a load-use hazard.
        exe_mem_r_en = 1'b1;
        br_taken = 1'b1;
        settle();
        chk_ctl("branch", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();

        // Clear counters before the memory tests.
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Memory freeze: window T..T+3 frozen, T+4 RELEASE, then RUN.
        mem_r_en = 1'b1;
        settle();
        chk_ctl("mem_T0", 1'b1, 1'b0, 1'b0, 1'b1);
        chk1("mem_T0.busy", a_busy, 1'b0);
        chk1("nofreeze.fall", s_fall, 1'b0);
        cyc();
        br_taken = 1'b1;
        settle();
        chk_ctl("mem_T1_br_suppressed", 1'b1, 1'b0, 1'b0, 1'b1);
        chk1("mem_T1.busy", a_busy, 1'b1);
        chk1("nofreeze.busy", s_busy, 1'b0);
        cyc();
        settle();
        chk1("mem_T2.fall", a_fall, 1'b1);
        cyc();
        settle();
        chk1("mem_T3.fall", a_fall, 1'b1);
        chk1("mem_T3.busy", a_busy, 1'b1);
        cyc();
        settle();
        chk_ctl("mem_T4_release_br", 1'b0, 1'b1, 1'b1, 1'b0);
        chk1("mem_T4.busy", a_busy, 1'b1);
        cyc();
        mem_r_en = 1'b0;
        br_taken = 1'b0;
        settle();
        chk_ctl("mem_T5_run", 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("mem_T5.busy", a_busy, 1'b0);
        chkn("mem.stall", a_stall, 32'd4);
        cyc();

        // Back-to-back stores: 4 frozen, 1 released, then a new window.
        exp_win[0] = 1'b1; exp_win[1] = 1'b1; exp_win[2] = 1'b1;
        exp_win[3] = 1'b1; exp_win[4] = 1'b0; exp_win[5] = 1'b1;
        exp_win[6] = 1'b1;
        mem_w_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            settle();
            chk1($sformatf("b2b_T%0d.fall", i), a_fall, exp_win[i]);
            cyc();
        end
        // Second WAIT cycle of the second window: reset abandons the access.
        rst = 1'b1;
        settle();
        chk1("b2b_rst.fall", a_fall, 1'b0);
        cyc();
        rst = 1'b0;
        mem_w_en = 1'b0;
        settle();
        chk1("after_rst.fall", a_fall, 1'b0);
        chk1("after_rst.busy", a_busy, 1'b0);
        chkn("after_rst.stall", a_stall, 32'd0);
        cyc();

        // Saturation: hold a hazard for 20 cycles.
        mem_wb_en = 1'b1; mem_dest = 5'd9; src1 = 5'd9;
        settle();
        chk1("sat.fpc", s_fpc, 1'b1);
        for (int i = 0; i < 14; i++) cyc();
        settle();
        chkn("sat.mid", {28'd0, s_stall}, 32'd14);
        for (int i = 0; i < 6; i++) cyc();
        clear_inputs();
        settle();
        chkn("sat.narrow", {28'd0, s_stall}, 32'd15);
        chkn("sat.wide", a_stall, 32'd20);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage core. Each cycle it decides whether the PC and IF/ID hold, whether a bubble goes into the ID/EX register, whether IF/ID is flushed, and whether the whole pipeline freezes for a fixed-latency data-memory access. It drives the ID/EX register's `hazard_Detected` input and the freeze/flush controls of the PC, IF/ID, EX/MEM and MEM/WB registers.

## Interface
- `MEM_WAIT_CYCLES`, default 4: number of cycles the pipeline freezes per data-memory access. Range 0..15; 0 disables freezing.
- `CNT_W`, default 32: width of the stall statistics counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `src1` input 5: ID-stage source register 1.
- `src2` input 5: ID-stage source register 2.
- `two_src` input 1: ID instruction actually reads `src2`.
- `forward_en` input 1: forwarding unit is active.
- `EXE_Dest` input 5: destination register in EXE.
- `EXE_WB_EN` input 1: write-back enable in EXE.
- `EXE_MEM_R_EN` input 1: EXE instruction is a load.
- `MEM_Dest` input 5: destination register in MEM.
- `MEM_WB_EN` input 1: write-back enable in MEM.
- `MEM_R_EN` input 1: read enable in MEM.
- `MEM_W_EN` input 1: write enable in MEM.
- `Br_taken` input 1: branch resolved taken in EXE.
- `freeze_PC` output 1: hold the PC and IF/ID.
- `hazard_Detected` output 1: load a bubble into ID/EX.
- `flush_IF` output 1: clear IF/ID.
- `freeze_all` output 1: hold every pipeline register and the PC.
- `mem_busy` output 1: FSM is not in RUN.
- `stall_cycles` output CNT_W: saturating count of stalled cycles.

## Operation
- **FSM states:** RUN, WAIT, RELEASE. A down-counter `cnt` is 4 bits wide.
- **mem_access** = `MEM_R_EN | MEM_W_EN`.
- **RUN**
  - If `mem_access` and `MEM_WAIT_CYCLES` > 0: `freeze_all` = 1 and `cnt` <= `MEM_WAIT_CYCLES` - 1.
  - Next state is WAIT if `MEM_WAIT_CYCLES` > 1, otherwise RELEASE.
- **WAIT**
  - `freeze_all` = 1 and `cnt` decrements each cycle.
  - When `cnt` == 1, next state is RELEASE.
  - Net effect: `freeze_all` is high for exactly `MEM_WAIT_CYCLES` consecutive cycles.
- **RELEASE**
  - `freeze_all` = 0 and the memory instruction advances.
  - `mem_access` is ignored in this state.
  - Next state is RUN.
- **Data hazard (dh)** applies only to sources that are nonzero.
  - Match on `src1`, or on `src2` when `two_src` = 1.
  - `forward_en` = 0: dh if (`EXE_WB_EN` and match `EXE_Dest`) or (`MEM_WB_EN` and match `MEM_Dest`).
  - `forward_en` = 1: dh only if `EXE_MEM_R_EN` and `EXE_WB_EN` and match `EXE_Dest` (load-use).
  - Register 0 never causes a hazard.
- **Output priority** (combinational from inputs and state):
  1. `rst`: all control outputs are 0.
  2. `freeze_all` = 1: `freeze_PC` = 1, `hazard_Detected` = 0, `flush_IF` = 0.
  3. `Br_taken`: `flush_IF` = 1, `hazard_Detected` = 1, `freeze_PC` = 0. The branch overrides dh.
  4. dh: `freeze_PC` = 1, `hazard_Detected` = 1, `flush_IF` = 0.
  5. Otherwise all are 0.
- **mem_busy** = (state != RUN), registered-state derived.
- **stall_cycles** increments on every non-reset cycle with `freeze_PC` = 1. It saturates at all-ones and never wraps.

## Timing
- Reset is synchronous. On the first edge with `rst` high: state <= RUN, `cnt` <= 0, `stall_cycles` <= 0.
- While `rst` is high, `freeze_PC`, `hazard_Detected`, `flush_IF` and `freeze_all` are 0.
- After reset, `mem_busy` = 0.
- All control outputs are same-cycle combinational, with zero latency from the hazard inputs. State and counters update on the rising edge of `clk`.
- **Memory access timing**
  - `mem_access` is first seen in RUN at cycle T.
  - `freeze_all` is high in cycles T through T+`MEM_WAIT_CYCLES`-1.
  - Cycle T+`MEM_WAIT_CYCLES` is RELEASE with `freeze_all` = 0; RUN follows.
- Back-to-back memory instructions re-trigger from RUN, so there is exactly one non-frozen cycle between freeze windows.
- A branch or data hazard arising during a freeze is suppressed. It is re-evaluated in RELEASE from the then-current inputs.
- Reset during WAIT: the next cycle is RUN with `freeze_all` = 0, and the pending access is abandoned.
- `MEM_WAIT_CYCLES` = 0: the FSM stays in RUN permanently and `mem_busy` is never set.

## Test plan
- **Load-use stall:** `forward_en`=1, `EXE_MEM_R_EN`=1, `EXE_WB_EN`=1, `EXE_Dest`=5, `src1`=5 -> same cycle `freeze_PC`=1, `hazard_Detected`=1, `flush_IF`=0. The same case with `src1`=0 and `EXE_Dest`=0 -> all outputs 0.
- **No-forwarding hazard:** `forward_en`=0, `MEM_WB_EN`=1, `MEM_Dest`=7, `src2`=7, `two_src`=1 -> stall. Setting `two_src`=0 -> no stall.
- **Branch priority:** `Br_taken`=1 together with the load-use case from the first scenario -> `flush_IF`=1, `hazard_Detected`=1, `freeze_PC`=0.
- **Memory freeze:** `MEM_WAIT_CYCLES`=4, `MEM_R_EN` pulse held -> `freeze_all` high for exactly 4 cycles, then 1 low cycle (RELEASE), then RUN. `mem_busy` is high for cycles 2..5. `stall_cycles` increments by 4.
- **Back-to-back and reset:** two consecutive `MEM_W_EN` instructions -> freeze windows 4 high, 1 low, 4 high. Asserting `rst` in the 2nd WAIT cycle -> next cycle `freeze_all`=0, `mem_busy`=0, `stall_cycles`=0.
- **Saturation:** `CNT_W`=4, hold a dh for 20 cycles -> `stall_cycles` stops at 15.
